// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared definitions for the phase sequencer.
// Holds the phase encoding, the PHASE bus width and the legal parameter
// ranges that the sequencer checks at elaboration.
package seq_ctrl_pkg;

    localparam int unsigned PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE = 2'b00,
        PH_GO   = 2'b01,
        PH_WARN = 2'b10,
        PH_STOP = 2'b11
    } phase_e;

    localparam int unsigned NCH_MIN   = 2;
    localparam int unsigned NCH_MAX   = 8;
    localparam int unsigned CNT_W_MIN = 2;
    localparam int unsigned CNT_W_MAX = 8;
    localparam int unsigned T_MIN     = 1;

    // Longest phase the counter can represent: lengths up to 2^cnt_w cycles.
    function automatic int unsigned t_max(input int unsigned cnt_w);
        return 32'd1 << cnt_w;
    endfunction

endpackage

// File: rtl/seq_phase_ctrl_if.sv
// seq_phase_ctrl_if: control/status bundle of the phase sequencer.
//   CLR, HOLD, REQ[NCH]        : driven by the master (requesters)
//   GRANT[NCH], CH_SEL, PHASE,
//   CNT[CNT_W], DONE           : driven by the slave (sequencer)
interface seq_phase_ctrl_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 4
);
    import seq_ctrl_pkg::*;

    localparam int unsigned SEL_W = $clog2(NCH);

    logic                 CLR;
    logic                 HOLD;
    logic [NCH-1:0]       REQ;
    logic [NCH-1:0]       GRANT;
    logic [SEL_W-1:0]     CH_SEL;
    logic [PHASE_W-1:0]   PHASE;
    logic [CNT_W-1:0]     CNT;
    logic                 DONE;

    modport master (
        output CLR, HOLD, REQ,
        input  GRANT, CH_SEL, PHASE, CNT, DONE
    );

    modport slave (
        input  CLR, HOLD, REQ,
        output GRANT, CH_SEL, PHASE, CNT, DONE
    );

endinterface

// File: rtl/seq_rr_arb.sv
// seq_rr_arb: combinational round-robin winner search.
//   req_i   : per-channel request
//   last_i  : last served channel; search starts at last_i+1 modulo NCH
//   valid_c : some request is present
//   win_c   : winning channel index (last_i when no request)
module seq_rr_arb #(
    parameter int unsigned NCH = 2
) (
    input  logic [NCH-1:0]         req_i,
    input  logic [$clog2(NCH)-1:0] last_i,
    output logic                   valid_c,
    output logic [$clog2(NCH)-1:0] win_c
);

    localparam int unsigned SEL_W = $clog2(NCH);

    // Scan farthest-first so the nearest requester after last_i overwrites.
    always_comb begin
        valid_c = 1'b0;
        win_c   = last_i;
        for (int unsigned k = NCH; k >= 1; k--) begin
            if (req_i[SEL_W'((32'(last_i) + k) % NCH)]) begin
                valid_c = 1'b1;
                win_c   = SEL_W'((32'(last_i) + k) % NCH);
            end
        end
    end

endmodule

// File: rtl/seq_phase_ctrl.sv
// seq_phase_ctrl: round-robin GO/WARN/STOP phase sequencer.
//   CK, RST   : clock, asynchronous active-high reset
//   ctl       : seq_phase_ctrl_if.slave (CLR, HOLD, REQ in; GRANT, CH_SEL,
//               PHASE, CNT, DONE out, all registered)
//   SE, SI, SO: scan enable / in / out, present only with SCAN_CHAIN_EN
//               defined; chain order SI -> state -> CNT -> CH_SEL -> GRANT
//               -> DONE -> SO.
module seq_phase_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned NCH    = 2,
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned T_GO   = 8,
    parameter int unsigned T_WARN = 3,
    parameter int unsigned T_STOP = 2
) (
    input  logic CK,
    input  logic RST,
`ifdef SCAN_CHAIN_EN
    input  logic SE,
    input  logic SI,
    output logic SO,
`endif
    seq_phase_ctrl_if.slave ctl
);

    localparam int unsigned SEL_W = $clog2(NCH);
    localparam logic [CNT_W-1:0] GO_LAST   = CNT_W'(T_GO - 1);
    localparam logic [CNT_W-1:0] WARN_LAST = CNT_W'(T_WARN - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(T_STOP - 1);

    // Elaboration-time parameter range check.
    if ((NCH < NCH_MIN) || (NCH > NCH_MAX) ||
        (CNT_W < CNT_W_MIN) || (CNT_W > CNT_W_MAX) ||
        (T_GO < T_MIN) || (T_GO > t_max(CNT_W)) ||
        (T_WARN < T_MIN) || (T_WARN > t_max(CNT_W)) ||
        (T_STOP < T_MIN) || (T_STOP > t_max(CNT_W))) begin : g_param_err
        $error("seq_phase_ctrl: parameter out of range");
    end

    phase_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [SEL_W-1:0] ch_sel_q, ch_sel_d;
    logic [NCH-1:0]   grant_q,  grant_d;
    logic             done_q,   done_d;

    logic             arb_valid_c;
    logic [SEL_W-1:0] arb_win_c;
    logic             rival_c;

    seq_rr_arb #(.NCH(NCH)) u_arb (
        .req_i   (ctl.REQ),
        .last_i  (ch_sel_q),
        .valid_c (arb_valid_c),
        .win_c   (arb_win_c)
    );

    // Any requester other than the channel currently served.
    assign rival_c = |(ctl.REQ & ~(NCH'(1) << ch_sel_q));

`ifdef SCAN_CHAIN_EN
    localparam int unsigned SCAN_W    = PHASE_W + CNT_W + SEL_W + NCH + 1;
    localparam int unsigned SEL_LSB   = 1 + NCH;
    localparam int unsigned CNT_LSB   = SEL_LSB + SEL_W;
    localparam int unsigned STATE_LSB = CNT_LSB + CNT_W;

    logic [SCAN_W-1:0] scan_nxt_c;
    assign scan_nxt_c = {SI, state_q, cnt_q, ch_sel_q, grant_q};
`endif

    // Next-state: CLR beats HOLD beats normal sequencing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_sel_d = ch_sel_q;
        grant_d  = grant_q;
        done_d   = 1'b0;

        if (ctl.CLR) begin
            state_d = PH_IDLE;
            cnt_d   = '0;
            grant_d = '0;
        end else if (!ctl.HOLD) begin
            unique case (state_q)
                PH_IDLE: begin
                    cnt_d   = '0;
                    grant_d = '0;
                    if (arb_valid_c) begin
                        state_d  = PH_GO;
                        ch_sel_d = arb_win_c;
                        grant_d  = NCH'(1) << arb_win_c;
                    end
                end
                PH_GO: begin
                    // Saturate at the last GO count until a rival shows up.
                    if (cnt_q == GO_LAST) begin
                        if (rival_c) begin
                            state_d = PH_WARN;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_WARN: begin
                    if (cnt_q == WARN_LAST) begin
                        state_d = PH_STOP;
                        cnt_d   = '0;
                        grant_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PH_STOP: begin
                    if (cnt_q == STOP_LAST) begin
                        state_d = PH_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end

`ifdef SCAN_CHAIN_EN
        // Scan shift replaces all functional updates.
        if (SE) begin
            state_d  = phase_e'(scan_nxt_c[STATE_LSB +: PHASE_W]);
            cnt_d    = scan_nxt_c[CNT_LSB +: CNT_W];
            ch_sel_d = scan_nxt_c[SEL_LSB +: SEL_W];
            grant_d  = scan_nxt_c[1 +: NCH];
            done_d   = scan_nxt_c[0];
        end
`endif
    end

    // State register; reset parks CH_SEL on NCH-1 so channel 0 wins first.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q  <= PH_IDLE;
            cnt_q    <= '0;
            ch_sel_q <= SEL_W'(NCH - 1);
            grant_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_sel_q <= ch_sel_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    assign ctl.PHASE  = state_q;
    assign ctl.CNT    = cnt_q;
    assign ctl.CH_SEL = ch_sel_q;
    assign ctl.GRANT  = grant_q;
    assign ctl.DONE   = done_q;
`ifdef SCAN_CHAIN_EN
    assign SO = done_q;
`endif

endmodule
